// File: rtl/router_switch_alloc.sv
// Switch allocator: per-output round-robin match of input head flits, locked until tail passes.
// Latency: allocation takes one cycle; transfers are combinational in the locked cycles after it.
// Backpressure: out_ready low or owner req low stalls the lock; the owner's FIFO is not read.

module router_switch_alloc_slice #(
  parameter int NPORT = 5,
  parameter int OW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] cand_i,
  input  logic [NPORT-1:0] req_i,
  input  logic [NPORT-1:0] tail_i,
  input  logic             ready_i,
  output logic             locked_o,
  output logic [OW-1:0]    owner_o,
  output logic [NPORT-1:0] sel_o,
  output logic             valid_o,
  output logic [NPORT-1:0] gnt_o
);
  logic             lock_q, lock_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [OW-1:0]    win;
  logic [OW-1:0]    idx;
  logic             found;
  logic             xfer;
  logic [NPORT-1:0] owner_oh;
  int               idx_i;

  // Round-robin search over candidates, starting just after the last winner
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    idx_i = 0;
    for (int k = 1; k <= NPORT; k++) begin
      idx_i = int'(ptr_q) + k;
      if (idx_i >= NPORT) idx_i = idx_i - NPORT;
      idx = OW'(idx_i);
      if (!found && cand_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Crossbar select held for the whole lock; a flit moves only when owner and downstream agree
  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    xfer              = lock_q && req_i[owner_q] && ready_i;
    sel_o             = lock_q ? owner_oh : '0;
    valid_o           = xfer;
    gnt_o             = xfer ? owner_oh : '0;
  end

  // IDLE -> LOCKED on a winner; LOCKED -> IDLE after the tail flit, remembering the owner for fairness
  always_comb begin
    lock_d  = lock_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (!lock_q) begin
      if (found) begin
        lock_d  = 1'b1;
        owner_d = win;
      end
    end else if (xfer && tail_i[owner_q]) begin
      lock_d = 1'b0;
      ptr_d  = owner_q;
    end
  end

  // State registers; reset pointer makes input 0 the first winner
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= OW'(NPORT - 1);
    end else begin
      lock_q  <= lock_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign locked_o = lock_q;
  assign owner_o  = owner_q;
endmodule

module router_switch_alloc #(
  parameter int NPORT = 5,
  parameter int DW    = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NPORT-1:0]       req,
  input  logic [NPORT*DW-1:0]    dest,
  input  logic [NPORT-1:0]       tail,
  input  logic [NPORT-1:0]       out_ready,
  output logic [NPORT-1:0]       in_gnt,
  output logic [NPORT*NPORT-1:0] sel,
  output logic [NPORT-1:0]       out_valid
);
  localparam int OW = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [NPORT-1:0] busy;
  logic [NPORT-1:0] slice_locked;
  logic [OW-1:0]    slice_owner [NPORT];
  logic [NPORT-1:0] slice_gnt   [NPORT];

  // An input that already owns an output may not compete for another one
  always_comb begin
    busy = '0;
    for (int j = 0; j < NPORT; j++) begin
      if (slice_locked[j]) busy[slice_owner[j]] = 1'b1;
    end
  end

  // Each input can be granted by at most one output, so OR-merging the slice grants is safe
  always_comb begin
    in_gnt = '0;
    for (int j = 0; j < NPORT; j++) begin
      in_gnt = in_gnt | slice_gnt[j];
    end
  end

  for (genvar j = 0; j < NPORT; j++) begin : g_out
    logic [NPORT-1:0] cand;

    // Candidates for this output: requesting, free, and routed here (out-of-range dest never matches)
    always_comb begin
      cand = '0;
      for (int i = 0; i < NPORT; i++) begin
        cand[i] = req[i] && !busy[i] && (dest[DW*i +: DW] == DW'(j));
      end
    end

    router_switch_alloc_slice #(
      .NPORT (NPORT),
      .OW    (OW)
    ) u_slice (
      .clk      (clk),
      .rst      (rst),
      .cand_i   (cand),
      .req_i    (req),
      .tail_i   (tail),
      .ready_i  (out_ready[j]),
      .locked_o (slice_locked[j]),
      .owner_o  (slice_owner[j]),
      .sel_o    (sel[NPORT*j +: NPORT]),
      .valid_o  (out_valid[j]),
      .gnt_o    (slice_gnt[j])
    );
  end
endmodule

// File: tb/tb_router_switch_alloc.sv
module tb_router_switch_alloc;
  localparam int N  = 5;
  localparam int DW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, tail, out_ready;
  logic [N*DW-1:0] dest;
  logic [N-1:0]   in_gnt, out_valid;
  logic [N*N-1:0] sel;

  int total = 0;
  int bad   = 0;

  // per-input flit sources: {tail, dest}
  logic [3:0] fq [N][$];
  // reference model: owner per output (-1 = free), last winner per output
  int m_owner [N];
  int m_ptr   [N];
  logic [N-1:0]   e_gnt, e_valid;
  logic [N*N-1:0] e_sel;
  // observation logs for directed checks
  logic [N-1:0] glog [$];
  logic [N-1:0] slog [$];
  int           olog [$];

  always #5 clk = ~clk;

  router_switch_alloc #(.NPORT(N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .dest      (dest),
    .tail      (tail),
    .out_ready (out_ready),
    .in_gnt    (in_gnt),
    .sel       (sel),
    .out_valid (out_valid)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int j = 0; j < N; j++) begin
      m_owner[j] = -1;
      m_ptr[j]   = N - 1;
    end
  endfunction

  function automatic void model_outputs();
    int o;
    e_gnt = '0; e_valid = '0; e_sel = '0;
    if (rst) begin
      for (int j = 0; j < N; j++) begin
        if (m_owner[j] >= 0) begin
          o = m_owner[j];
          e_sel[N*j + o] = 1'b1;
          if (req[o] && out_ready[j]) begin
            e_valid[j] = 1'b1;
            e_gnt[o]   = 1'b1;
          end
        end
      end
    end
  endfunction

  // winner = requesting free input with the smallest circular distance past the last winner
  function automatic void model_edge();
    int nown [N];
    int nptr [N];
    logic [N-1:0] busy;
    int o, best, bestd, d;
    if (!rst) begin
      model_reset();
      return;
    end
    busy = '0;
    for (int j = 0; j < N; j++) if (m_owner[j] >= 0) busy[m_owner[j]] = 1'b1;
    for (int j = 0; j < N; j++) begin
      nown[j] = m_owner[j];
      nptr[j] = m_ptr[j];
      if (m_owner[j] >= 0) begin
        o = m_owner[j];
        if (req[o] && out_ready[j] && tail[o]) begin
          nown[j] = -1;
          nptr[j] = o;
        end
      end else begin
        best = -1; bestd = N;
        for (int i = 0; i < N; i++) begin
          if (req[i] && !busy[i] && int'(dest[DW*i +: DW]) == j) begin
            d = (i - m_ptr[j] - 1 + 2*N) % N;
            if (d < bestd) begin bestd = d; best = i; end
          end
        end
        nown[j] = best;
      end
    end
    for (int j = 0; j < N; j++) begin
      m_owner[j] = nown[j];
      m_ptr[j]   = nptr[j];
    end
  endfunction

  task automatic drive();
    logic [3:0] f;
    for (int i = 0; i < N; i++) begin
      if (fq[i].size() > 0) begin
        f = fq[i][0];
        req[i] = 1'b1;
        dest[DW*i +: DW] = f[2:0];
        tail[i] = f[3];
      end else begin
        req[i] = 1'b0;
        dest[DW*i +: DW] = 3'($urandom);
        tail[i] = 1'($urandom);
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_outputs();
    chk("in_gnt", 32'(in_gnt), 32'(e_gnt));
    chk("sel", 32'(sel), 32'(e_sel));
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    glog.push_back(in_gnt);
    slog.push_back(sel[14:10]);
    for (int i = 0; i < N; i++) if (out_valid[4] && sel[N*4 + i]) olog.push_back(i);
    @(posedge clk);
    model_edge();
    for (int i = 0; i < N; i++) if (e_gnt[i] && fq[i].size() > 0) void'(fq[i].pop_front());
    #1;
    drive();
  endtask

  task automatic push_pkt(input int i, input int d, input int len);
    for (int k = 0; k < len; k++) fq[i].push_back({(k == len - 1) ? 1'b1 : 1'b0, 3'(d)});
  endtask

  function automatic int order4();
    while (olog.size() < 4) olog.push_back(9);
    return olog[0]*1000 + olog[1]*100 + olog[2]*10 + olog[3];
  endfunction

  initial begin
    int ii, len;
    rst = 1'b1; req = '0; dest = '0; tail = '0; out_ready = '1;
    model_reset();
    #2 rst = 1'b0;

    // reset with random requests: everything quiet
    for (int c = 0; c < 3; c++) begin
      req = 5'($urandom); dest = 15'($urandom); tail = 5'($urandom);
      #1;
      chk("rst_gnt", 32'(in_gnt), 0);
      chk("rst_sel", 32'(sel), 0);
      chk("rst_valid", 32'(out_valid), 0);
      cycle();
    end
    rst = 1'b1;
    glog.delete();
    repeat (3) cycle();
    chk("release_idle", 32'(glog[0] | glog[1] | glog[2]), 0);

    // single 3-flit packet, input 0 -> output 2
    push_pkt(0, 2, 3); drive();
    glog.delete(); slog.delete();
    repeat (6) cycle();
    chk("t2_gnt0", 32'({glog[0][0], glog[1][0], glog[2][0], glog[3][0], glog[4][0], glog[5][0]}), 32'b011100);
    chk("t2_sel_alloc", 32'(slog[0]), 0);
    chk("t2_sel_lock", 32'(slog[1]), 32'b00001);
    chk("t2_sel_last", 32'(slog[3]), 32'b00001);
    chk("t2_sel_idle", 32'(slog[4]), 0);

    // contention on output 4, twice
    for (int r = 0; r < 2; r++) begin
      push_pkt(1, 4, 2); push_pkt(3, 4, 2); drive();
      olog.delete(); glog.delete();
      repeat (7) cycle();
      chk("t3_count", olog.size(), 4);
      chk("t3_order", order4(), 1133);
      chk("t3_bubble", 32'({glog[1], glog[3], glog[4]}), 32'({5'h02, 5'h00, 5'h08}));
    end

    // backpressure on output 2 mid-packet
    push_pkt(0, 2, 4); drive();
    glog.delete(); slog.delete();
    cycle(); cycle();
    out_ready[2] = 1'b0;
    cycle(); cycle();
    out_ready[2] = 1'b1;
    repeat (4) cycle();
    chk("t4_gnt0", 32'({glog[0][0], glog[1][0], glog[2][0], glog[3][0], glog[4][0], glog[5][0], glog[6][0], glog[7][0]}), 32'b01001110);
    chk("t4_sel_stall", 32'({slog[2], slog[3]}), 32'({5'b00001, 5'b00001}));
    chk("t4_drained", fq[0].size(), 0);

    // out-of-range destination on input 4 does not disturb input 0
    push_pkt(4, 6, 1); push_pkt(0, 1, 2); drive();
    glog.delete();
    repeat (5) cycle();
    chk("t5_gnt4", 32'(glog[0][4] | glog[1][4] | glog[2][4] | glog[3][4] | glog[4][4]), 0);
    chk("t5_gnt0", 32'({glog[0][0], glog[1][0], glog[2][0], glog[3][0], glog[4][0]}), 32'b01100);
    chk("t5_stuck", fq[4].size(), 1);
    fq[4].delete(); drive();

    // reset during the 2nd flit of a 4-flit packet
    push_pkt(2, 0, 4); drive();
    cycle(); cycle();
    #1;
    chk("t6_pre", 32'(in_gnt), 32'h04);
    #1 rst = 1'b0;
    model_reset();
    #1;
    chk("t6_gnt", 32'(in_gnt), 0);
    chk("t6_sel", 32'(sel), 0);
    chk("t6_valid", 32'(out_valid), 0);
    for (int i = 0; i < N; i++) fq[i].delete();
    cycle();
    rst = 1'b1;
    push_pkt(2, 0, 2); drive();
    glog.delete();
    repeat (4) cycle();
    chk("t6_fresh", 32'({glog[0][2], glog[1][2], glog[2][2], glog[3][2]}), 32'b0110);

    // random traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        ii = $urandom_range(0, N - 1);
        if (fq[ii].size() < 6) begin
          len = $urandom_range(1, 4);
          for (int k = 0; k < len; k++)
            fq[ii].push_back({(k == len - 1) ? 1'b1 : 1'b0,
                              (k == 0) ? 3'($urandom_range(0, N - 1)) : 3'($urandom)});
        end
      end
      out_ready = 5'($urandom) | 5'($urandom);
      drive();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
